// File: rtl/col_window_gen.sv
// -----------------------------------------------------------------------------
// col_window_gen
//   Builds the 5-pixel vertical column for a 5x5 smoother from a raster-order
//   grayscale stream. Four rotating line buffers hold the four most recent
//   rows. For every accepted pixel (x,y) the column {y-4, y-3, y-2, y-1, y}
//   at column x is registered one cycle later.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset
//   i_valid  : i_pixel carries a valid raster pixel this cycle
//   i_pixel  : 8-bit grayscale pixel, row-major, left to right
//   o_valid  : column valid (only for rows y >= 4), one pulse per pixel
//   o_col0   : [39:32]=row y-4 ... [7:0]=row y, all at column x
//   o_x      : column index of the emitted column
//   o_y      : row index of the bottom pixel of the emitted column
//   o_eof    : pulse with the column of the last pixel of the frame
// -----------------------------------------------------------------------------
module col_window_gen #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_pixel,
  output logic        o_valid,
  output logic [39:0] o_col0,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_eof
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [1:0]  ptr_q, ptr_d;

  logic        valid_q, valid_d;
  logic        eof_q, eof_d;
  logic [39:0] col_q, col_d;
  logic [9:0]  ox_q, ox_d;
  logic [8:0]  oy_q, oy_d;

  // Line buffers are never reset: output is gated by the row count, so stale
  // contents are always overwritten before they can reach a valid column.
  logic [7:0]  line_q [4][WIDTH];
  logic [7:0]  rd [4];

  logic [XW-1:0] x_idx;
  logic          x_last;
  logic          y_last;
  logic          accept;

  assign x_idx  = x_q[XW-1:0];
  assign x_last = (x_q == 10'(WIDTH - 1));
  assign y_last = (y_q == 9'(HEIGHT - 1));
  assign accept = i_valid && !i_rst;

  // Slot ptr holds the oldest row (y-4); the following slots, mod 4, hold
  // progressively newer rows up to y-1.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd[k] = line_q[ptr_q + 2'(k)][x_idx];
    end
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    ptr_d = ptr_q;
    if (i_valid) begin
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          // New frame restarts the rotation so rows 0..3 refill cleanly.
          y_d   = '0;
          ptr_d = '0;
        end else begin
          y_d   = y_q + 9'd1;
          ptr_d = ptr_q + 2'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_comb begin
    valid_d = 1'b0;
    eof_d   = 1'b0;
    col_d   = col_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    if (i_valid) begin
      valid_d = (y_q >= 9'd4);
      eof_d   = x_last && y_last;
      col_d   = {rd[0], rd[1], rd[2], rd[3], i_pixel};
      ox_d    = x_q;
      oy_d    = y_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q     <= '0;
      y_q     <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      col_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
      col_q   <= col_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  // Nonblocking write: the same-cycle reads above see the old row y-4.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      line_q[ptr_q][x_idx] <= i_pixel;
    end
  end

  assign o_valid = valid_q;
  assign o_eof   = eof_q;
  assign o_col0  = col_q;
  assign o_x     = ox_q;
  assign o_y     = oy_q;

endmodule

// File: tb/tb_col_window_gen.sv
// -----------------------------------------------------------------------------
// tb_col_window_gen
//   Self-checking bench for col_window_gen (WIDTH=8, HEIGHT=6). A reference
//   model keeps the whole current frame as a 2-D image and derives each
//   expected column directly from the rows above the pixel.
// -----------------------------------------------------------------------------
module tb_col_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_pixel;
  logic        o_valid;
  logic [39:0] o_col0;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic        o_eof;

  col_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_pixel (i_pixel),
    .o_valid (o_valid),
    .o_col0  (o_col0),
    .o_x     (o_x),
    .o_y     (o_y),
    .o_eof   (o_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [7:0]  img [H][W];
  int          mx, my;
  logic        e_valid, e_eof, e_col_known;
  logic [39:0] e_col;
  logic [9:0]  e_x;
  logic [8:0]  e_y;

  // observation capture
  logic [39:0] cap [H][W];
  int          nvalid;
  logic        seen_first;
  logic [39:0] first_col;
  int          n_eof;
  int          eof_x, eof_y;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic clear_capture();
    nvalid     = 0;
    seen_first = 1'b0;
    first_col  = '0;
    n_eof      = 0;
    eof_x      = -1;
    eof_y      = -1;
  endtask

  task automatic step(input logic v, input logic [7:0] p, input logic r);
    i_valid = v;
    i_pixel = p;
    i_rst   = r;
    @(posedge clk);
    if (r) begin
      mx = 0; my = 0;
      e_valid = 1'b0; e_eof = 1'b0;
      e_col = '0; e_x = '0; e_y = '0;
      e_col_known = 1'b1;
    end else if (v) begin
      img[my][mx] = p;
      e_valid = (my >= 4);
      e_eof   = (mx == W - 1) && (my == H - 1);
      e_x     = 10'(mx);
      e_y     = 9'(my);
      if (my >= 4) begin
        e_col = {img[my-4][mx], img[my-3][mx], img[my-2][mx], img[my-1][mx], p};
        e_col_known = 1'b1;
      end else begin
        e_col_known = 1'b0;
      end
      mx++;
      if (mx == W) begin
        mx = 0;
        my++;
        if (my == H) my = 0;
      end
    end else begin
      e_valid = 1'b0;
      e_eof   = 1'b0;
    end
    #1;
    chk("valid", 64'(o_valid), 64'(e_valid));
    chk("eof",   64'(o_eof),   64'(e_eof));
    chk("x",     64'(o_x),     64'(e_x));
    chk("y",     64'(o_y),     64'(e_y));
    if (e_col_known) chk("col", 64'(o_col0), 64'(e_col));
    if (o_valid) begin
      nvalid++;
      if (o_y < 9'(H) && o_x < 10'(W)) cap[o_y][o_x] = o_col0;
      if (!seen_first) begin
        seen_first = 1'b1;
        first_col  = o_col0;
      end
    end
    if (o_eof) begin
      n_eof++;
      eof_x = int'(o_x);
      eof_y = int'(o_y);
    end
  endtask

  // mode 0: continuous; 1: idle cycle before each pixel of row 4;
  // 2: random stalls and random pixel values
  task automatic stream_frame(input int offset, input int mode);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        logic [7:0] p;
        p = (mode == 2) ? 8'($urandom_range(0, 255)) : 8'(16 * y + x + offset);
        if (mode == 1 && y == 4) step(1'b0, 8'($urandom), 1'b0);
        if (mode == 2) begin
          while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'b0);
        end
        step(1'b1, p, 1'b0);
      end
    end
  endtask

  initial begin
    logic [39:0] c;
    i_rst = 1'b1; i_valid = 1'b0; i_pixel = '0;
    mx = 0; my = 0;
    e_valid = 0; e_eof = 0; e_col = '0; e_x = '0; e_y = '0; e_col_known = 1'b1;
    clear_capture();

    // reset then idle
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);

    // clean frame
    clear_capture();
    stream_frame(0, 0);
    chk("nvalid_clean", 64'(nvalid), 64'(16));
    chk("col_0_4", 64'(cap[4][0]), 64'h00_0010203040);
    chk("col_3_4", 64'(cap[4][3]), 64'h00_0313233343);
    chk("col_7_5", 64'(cap[5][7]), 64'h00_1727374757);
    chk("eof_cnt", 64'(n_eof), 64'(1));
    chk("eof_pos", 64'(eof_x * 16 + eof_y), 64'(7 * 16 + 5));

    // second frame with no bubble
    clear_capture();
    stream_frame(128, 0);
    chk("nvalid_wrap", 64'(nvalid), 64'(16));
    chk("first_wrap", 64'(first_col), 64'h00_8090A0B0C0);

    // stalls in row 4
    clear_capture();
    stream_frame(0, 1);
    chk("nvalid_stall", 64'(nvalid), 64'(16));
    for (int x = 0; x < W; x++) begin
      c = {8'(x), 8'(16 + x), 8'(32 + x), 8'(48 + x), 8'(64 + x)};
      chk("stall_col", 64'(cap[4][x]), 64'(c));
    end

    // reset mid-frame at pixel (2,4)
    clear_capture();
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == 4 && x == 2) break;
        step(1'b1, 8'(16 * y + x), 1'b0);
      end
    end
    chk("nvalid_pre_rst", 64'(nvalid), 64'(2));
    step(1'b1, 8'(16 * 4 + 2), 1'b1);
    clear_capture();
    stream_frame(0, 0);
    chk("nvalid_rst", 64'(nvalid), 64'(16));
    chk("rst_col_0_4", 64'(cap[4][0]), 64'h00_0010203040);
    chk("rst_col_7_5", 64'(cap[5][7]), 64'h00_1727374757);

    // randomized frames with random stalls
    for (int f = 0; f < 3; f++) begin
      clear_capture();
      stream_frame(0, 2);
      chk("nvalid_rand", 64'(nvalid), 64'(16));
      chk("eof_rand", 64'(n_eof), 64'(1));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/col_window_gen.md
Name: col_window_gen

Overview:
- Builds the 5-pixel vertical column that feeds the 5x5 Gaussian smoother's `i_col0` port, from a raster-order grayscale pixel stream.
- Stores the four most recent image rows in rotating line buffers. For each incoming pixel it emits the 5-pixel column ending at that pixel, ordered top (oldest row) to bottom (newest row).
- Sits between the camera/frame-read front end and the smoother.

Parameters:
- WIDTH, 640, pixels per row (line-buffer depth and column-counter wrap).
- HEIGHT, 480, rows per frame (row-counter wrap).

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  `i_pixel` is a valid raster pixel this cycle.
- i_pixel  input  8  grayscale pixel, raster order, row-major, left to right.
- o_valid  output  1  `o_col0`/`o_x`/`o_y` are valid this cycle (single-cycle pulse per accepted column).
- o_col0  output  40  column, up to down: [39:32]=row y-4, [31:24]=y-3, [23:16]=y-2, [15:8]=y-1, [7:0]=row y, all at column x.
- o_x  output  10  column index x of the emitted column.
- o_y  output  9  row index y of the bottom pixel of the emitted column.
- o_eof  output  1  one-cycle pulse coincident with the column for the last pixel of the frame (x=WIDTH-1, y=HEIGHT-1).

Behaviour:
- Reset, while `i_rst`=1 at a clock edge:
  - x_cnt=0, y_cnt=0, row pointer=0.
  - o_valid=0, o_eof=0, o_col0=0, o_x=0, o_y=0.
  - Line-buffer contents are not cleared; they are don't-care because output is gated by the row count.
- Reset asserted mid-frame: the frame is abandoned. The next accepted pixel is treated as (0,0) and no column is emitted until 4 new rows have been stored.
- Stall:
  - `i_valid`=0: counters, pointers and memories hold.
  - o_valid and o_eof drop to 0 the next cycle.
  - o_col0, o_x and o_y hold their last values.
- Accepted pixel (`i_valid`=1) at position (x,y):
  - Read line buffers L[(ptr+0..3) mod 4][x]; these hold rows y-4..y-1, oldest first.
  - Write `i_pixel` into L[ptr][x], the slot holding row y-4, which is now consumed. Read-before-write at the same address in the same cycle returns the old data.
  - Register {rows y-4..y-1, i_pixel} into o_col0.
  - o_x<=x, o_y<=y.
  - o_valid<=(y>=4).
  - o_eof<=(x==WIDTH-1 && y==HEIGHT-1).
  - Latency: exactly 1 cycle from accepted pixel to o_valid.
- Counters:
  - x increments per accepted pixel.
  - At x==WIDTH-1: x wraps to 0, y increments, and ptr advances mod 4.
  - At x==WIDTH-1 && y==HEIGHT-1: x=0, y=0, ptr=0 (new frame). The first 4 rows of the new frame emit no valid columns, so there is no cross-frame mixing at the output.
- Border policy: no replication or padding.
  - Rows 0..3 produce o_valid=0.
  - Every pixel in rows 4..HEIGHT-1 produces exactly one valid column.
  - Total valid columns per frame = WIDTH*(HEIGHT-4).
- Memory: 4 × WIDTH × 8 bits, one write and four reads per accepted pixel. Registers or inferred RAM are both acceptable, provided read-before-write semantics and 1-cycle output latency are preserved.
- Back-to-back frames with `i_valid` held high continuously are supported with no bubble.

Test Plan (WIDTH=8, HEIGHT=6, pixel(x,y)=16*y+x unless stated):
- Reset then idle:
  - Stimulus: hold `i_rst`=1 for 3 cycles, then `i_valid`=0 for 10 cycles.
  - Required: o_valid=0, o_eof=0, o_col0=0 throughout.
- Fill phase:
  - Stimulus: stream rows 0–3 continuously (32 pixels).
  - Required: o_valid stays 0.
  - Then pixel (0,4) gives o_valid=1 on the next cycle with o_col0=40'h0010203040, o_x=0, o_y=4.
- Mid-row column:
  - Stimulus: accept pixel (3,4).
  - Required: next cycle o_col0=40'h0313233343, o_x=3, o_y=4.
  - Then pixel (7,5) gives o_col0=40'h1727374757 and o_eof=1.
  - Exactly 16 valid pulses in the frame.
- Stall:
  - Stimulus: during row 4, deassert `i_valid` every other cycle.
  - Required: same 8 o_col0 values as the unstalled run.
  - o_valid is 0 on cycles following `i_valid`=0; outputs hold.
- Frame wrap:
  - Stimulus: second frame immediately after the first, with pixel=16*y+x+128.
  - Required: no o_valid during new rows 0–3.
  - First new column is 40'h8090A0B0C0; no stale first-frame data appears.
- Reset mid-frame:
  - Stimulus: assert `i_rst` at pixel (2,4), then restream a full frame.
  - Required: o_valid stays 0 until new row 4.
  - Output then matches the clean-frame run exactly.
